mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/core_pkg.sv | 13 +
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/arb_wait_counter.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 85 ++++++++
 tb/tb_mem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared types for the memory port arbiter: response ownership and the
// default fetch starvation limit.
package core_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } resp_own_e;

    localparam int unsigned MAX_WAIT_DEFAULT = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-side signals of the arbiter.
// slave is the arbiter view; master is the requester/memory environment view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_gnt;
    logic              fetch_flush;
    logic              fetch_rvalid;
    logic [DATA_W-1:0] fetch_rdata;

    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_gnt;
    logic              data_rvalid;
    logic [DATA_W-1:0] data_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              block_inst;

    modport slave (
        input  fetch_req, fetch_addr, fetch_flush,
        input  data_req, data_we, data_addr, data_wdata,
        input  mem_rdata,
        output fetch_gnt, fetch_rvalid, fetch_rdata,
        output data_gnt, data_rvalid, data_rdata,
        output mem_addr, mem_we, mem_wdata, block_inst
    );

    modport master (
        output fetch_req, fetch_addr, fetch_flush,
        output data_req, data_we, data_addr, data_wdata,
        output mem_rdata,
        input  fetch_gnt, fetch_rvalid, fetch_rdata,
        input  data_gnt, data_rvalid, data_rdata,
        input  mem_addr, mem_we, mem_wdata, block_inst
    );

endinterface

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive cycles the fetch requester was denied;
// starved goes high once the count reaches MAX_WAIT.
module arb_wait_counter
    import core_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fetch_req,
    input  logic fetch_gnt,
    output logic starved
);

    localparam logic [3:0] LIMIT = 4'(MAX_WAIT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // NOTE: combinational blocks assign a default first so no path leaves cnt_d unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (!fetch_req || fetch_gnt) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-cycle-latency memory port between a fetch and a data
// requester: data has priority unless fetch has been starved for MAX_WAIT cycles.
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    logic              starved;
    logic              fetch_gnt;
    logic              data_gnt;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              fetch_rvalid;
    logic              data_rvalid;

    resp_own_e         resp_own_q;
    resp_own_e         resp_own_d;
    logic [ADDR_W-1:0] last_addr_q;
    logic [ADDR_W-1:0] last_addr_d;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch_req (bus.fetch_req),
        .fetch_gnt (fetch_gnt),
        .starved   (starved)
    );

    // Grants are gated by rst_n so nothing is granted while reset is held.
    // A flush only suppresses the fetch grant; data still loses to a starved fetch.
    always_comb begin
        fetch_gnt = rst_n && bus.fetch_req && (starved || !bus.data_req) && !bus.fetch_flush;
        data_gnt  = rst_n && bus.data_req && !(bus.fetch_req && starved);
    end

    always_comb begin
        last_addr_d = last_addr_q;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        resp_own_d  = OWN_NONE;
        if (fetch_gnt) begin
            last_addr_d = bus.fetch_addr;
            resp_own_d  = OWN_FETCH;
        end else if (data_gnt) begin
            last_addr_d = bus.data_addr;
            mem_we      = bus.data_we;
            mem_wdata   = bus.data_wdata;
            resp_own_d  = bus.data_we ? OWN_NONE : OWN_DATA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_own_q  <= OWN_NONE;
            last_addr_q <= '0;
        end else begin
            resp_own_q  <= resp_own_d;
            last_addr_q <= last_addr_d;
        end
    end

    assign fetch_rvalid = (resp_own_q == OWN_FETCH) && !bus.fetch_flush;
    assign data_rvalid  = (resp_own_q == OWN_DATA);

    assign bus.fetch_gnt    = fetch_gnt;
    assign bus.data_gnt     = data_gnt;
    assign bus.block_inst   = data_gnt;
    assign bus.mem_addr     = last_addr_d;
    assign bus.mem_we       = mem_we;
    assign bus.mem_wdata    = mem_wdata;
    assign bus.fetch_rvalid = fetch_rvalid;
    assign bus.data_rvalid  = data_rvalid;
    assign bus.fetch_rdata  = fetch_rvalid ? bus.mem_rdata : '0;
    assign bus.data_rdata   = data_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: grants are checked inline per task,
// read responses are checked by a scoreboard of expected per-cycle results.
module tb_mem_port_arbiter;

    localparam int MAX_WAIT = 4;

    typedef struct {
        int unsigned due;
        logic        fv;
        logic [31:0] fd;
        logic        dv;
        logic [31:0] dd;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int unsigned cyc;
    int          checks;
    int          errors;
    exp_t        sb[$];
    logic [31:0] mem_model [logic [31:0]];

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'hA5C3_0000;
    endfunction

    // Memory model: one-cycle read latency, writes land on the edge.
    always @(posedge clk) begin
        if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
        bus.mem_rdata <= mem_read(bus.mem_addr);
    end

    task automatic drive(input logic fr, input logic [31:0] fa, input logic ff,
                         input logic dr, input logic dwe, input logic [31:0] da,
                         input logic [31:0] dwd);
        bus.fetch_req   = fr;
        bus.fetch_addr  = fa;
        bus.fetch_flush = ff;
        bus.data_req    = dr;
        bus.data_we     = dwe;
        bus.data_addr   = da;
        bus.data_wdata  = dwd;
    endtask

    task automatic push_fetch(input logic [31:0] d);
        sb.push_back('{cyc + 1, 1'b1, d, 1'b0, 32'h0});
    endtask

    task automatic push_data(input logic [31:0] d);
        sb.push_back('{cyc + 1, 1'b0, 32'h0, 1'b1, d});
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            e = '{0, 1'b0, 32'h0, 1'b0, 32'h0};
            if (sb.size() > 0 && sb[0].due == cyc) e = sb.pop_front();
            checks++;
            if (bus.fetch_rvalid !== e.fv) begin errors++; $display("FAIL fetch_rvalid cyc=%0d: got %b want %b", cyc, bus.fetch_rvalid, e.fv); end
            checks++;
            if (bus.fetch_rdata !== e.fd) begin errors++; $display("FAIL fetch_rdata cyc=%0d: got %h want %h", cyc, bus.fetch_rdata, e.fd); end
            checks++;
            if (bus.data_rvalid !== e.dv) begin errors++; $display("FAIL data_rvalid cyc=%0d: got %b want %b", cyc, bus.data_rvalid, e.dv); end
            checks++;
            if (bus.data_rdata !== e.dd) begin errors++; $display("FAIL data_rdata cyc=%0d: got %h want %h", cyc, bus.data_rdata, e.dd); end
            checks++;
            if (bus.fetch_gnt === 1'b1 && bus.data_gnt === 1'b1) begin errors++; $display("FAIL gnt_exclusive cyc=%0d: got both grants want at most one", cyc); end
        end
    endtask

    task automatic check_all_zero(input string tag);
        logic [31:0] agg;
        agg = {26'h0, bus.fetch_gnt, bus.data_gnt, bus.fetch_rvalid, bus.data_rvalid, bus.mem_we, bus.block_inst};
        checks++;
        if (agg !== 32'h0) begin errors++; $display("FAIL %s_flags: got %h want 0", tag, agg); end
        checks++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL %s_mem: got addr %h wdata %h want 0", tag, bus.mem_addr, bus.mem_wdata); end
        checks++;
        if (bus.fetch_rdata !== 32'h0 || bus.data_rdata !== 32'h0) begin errors++; $display("FAIL %s_rdata: got %h/%h want 0", tag, bus.fetch_rdata, bus.data_rdata); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h200, 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic test_fetch_read();
        @(negedge clk);
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #3;
        checks++;
        if (bus.fetch_gnt !== 1'b1 || bus.data_gnt !== 1'b0) begin errors++; $display("FAIL fetch_read_gnt: got f=%b d=%b want f=1 d=0", bus.fetch_gnt, bus.data_gnt); end
        checks++;
        if (bus.mem_addr !== 32'h100 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL fetch_read_mem: got addr %h we %b want 100/0", bus.mem_addr, bus.mem_we); end
        push_fetch(32'hDEAD_BEEF);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #3;
        checks++;
        if (bus.mem_addr !== 32'h100 || bus.mem_we !== 1'b0 || bus.mem_wdata !== 32'h0) begin
            errors++; $display("FAIL idle_hold: got addr %h we %b wdata %h want 100/0/0", bus.mem_addr, bus.mem_we, bus.mem_wdata);
        end
    endtask

    task automatic test_priority();
        @(negedge clk);
        drive(1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0);
        #3;
        checks++;
        if (bus.data_gnt !== 1'b1 || bus.block_inst !== 1'b1 || bus.fetch_gnt !== 1'b0) begin
            errors++; $display("FAIL priority_data: got d=%b blk=%b f=%b want 1/1/0", bus.data_gnt, bus.block_inst, bus.fetch_gnt);
        end
        checks++;
        if (bus.mem_addr !== 32'h200) begin errors++; $display("FAIL priority_addr: got %h want 200", bus.mem_addr); end
        push_data(mem_read(32'h200));
        @(negedge clk);
        drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #3;
        checks++;
        if (bus.fetch_gnt !== 1'b1 || bus.block_inst !== 1'b0 || bus.mem_addr !== 32'h104) begin
            errors++; $display("FAIL priority_fetch_after: got f=%b blk=%b addr %h want 1/0/104", bus.fetch_gnt, bus.block_inst, bus.mem_addr);
        end
        push_fetch(mem_read(32'h104));
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_starvation(input string tag, input int base);
        logic        want_f;
        logic [31:0] da;
        for (int i = 0; i <= MAX_WAIT + 1; i++) begin
            if (i > 0 || tag != "post_reset") @(negedge clk);
            da = 32'(base + 4 * i);
            drive(1'b1, 32'h180, 1'b0, 1'b1, 1'b0, da, 32'h0);
            if (tag == "post_reset") rst_n = 1'b1;
            #3;
            want_f = (i == MAX_WAIT);
            checks++;
            if (bus.fetch_gnt !== want_f || bus.data_gnt !== !want_f) begin
                errors++; $display("FAIL %s_gnt i=%0d: got f=%b d=%b want f=%b d=%b", tag, i, bus.fetch_gnt, bus.data_gnt, want_f, !want_f);
            end
            checks++;
            if (bus.mem_addr !== (want_f ? 32'h180 : da)) begin errors++; $display("FAIL %s_addr i=%0d: got %h want %h", tag, i, bus.mem_addr, want_f ? 32'h180 : da); end
            if (want_f) push_fetch(mem_read(32'h180));
            else        push_data(mem_read(da));
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_store();
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h300, 32'h1234_5678);
        #3;
        checks++;
        if (bus.data_gnt !== 1'b1 || bus.mem_we !== 1'b1) begin errors++; $display("FAIL store_gnt_we: got %b/%b want 1/1", bus.data_gnt, bus.mem_we); end
        checks++;
        if (bus.mem_addr !== 32'h300 || bus.mem_wdata !== 32'h1234_5678) begin
            errors++; $display("FAIL store_bus: got addr %h wdata %h want 300/12345678", bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0);
        #3;
        checks++;
        if (bus.data_gnt !== 1'b1 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL store_readback_gnt: got %b/%b want 1/0", bus.data_gnt, bus.mem_we); end
        push_data(32'h1234_5678);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_flush();
        @(negedge clk);
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #3;
        checks++;
        if (bus.fetch_gnt !== 1'b1) begin errors++; $display("FAIL flush_first_gnt: got %b want 1", bus.fetch_gnt); end
        @(negedge clk);
        drive(1'b1, 32'h108, 1'b1, 1'b1, 1'b0, 32'h204, 32'h0);
        #3;
        checks++;
        if (bus.fetch_gnt !== 1'b0 || bus.data_gnt !== 1'b1) begin
            errors++; $display("FAIL flush_gnt: got f=%b d=%b want f=0 d=1", bus.fetch_gnt, bus.data_gnt);
        end
        push_data(mem_read(32'h204));
        @(negedge clk);
        drive(1'b1, 32'h10C, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #3;
        checks++;
        if (bus.fetch_gnt !== 1'b1 || bus.mem_addr !== 32'h10C) begin errors++; $display("FAIL flush_after_gnt: got %b addr %h want 1/10c", bus.fetch_gnt, bus.mem_addr); end
        push_fetch(mem_read(32'h10C));
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i % 2 == 0) begin
                a = 32'(32'h500 + 4 * i);
                drive(1'b1, a, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end else begin
                a = 32'(32'h600 + 4 * i);
                drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, a, 32'h0);
            end
            #3;
            checks++;
            if (bus.fetch_gnt !== (i % 2 == 0) || bus.data_gnt !== (i % 2 == 1) || bus.mem_addr !== a) begin
                errors++; $display("FAIL b2b i=%0d: got f=%b d=%b addr %h want addr %h", i, bus.fetch_gnt, bus.data_gnt, bus.mem_addr, a);
            end
            if (i % 2 == 0) push_fetch(mem_read(a));
            else            push_data(mem_read(a));
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive(1'b1, 32'h110, 1'b0, 1'b1, 1'b0, 32'h208, 32'h0);
        #3;
        checks++;
        if (bus.data_gnt !== 1'b1) begin errors++; $display("FAIL reset_mid_load_gnt: got %b want 1", bus.data_gnt); end
        @(negedge clk);
        drive(1'b1, 32'h110, 1'b0, 1'b1, 1'b1, 32'h208, 32'hCAFE_F00D);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        @(negedge clk);
        // Release happens inside the starvation scenario, in the same cycle as its first request.
        test_starvation("post_reset", 32'h700);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        mem_model[32'h100] = 32'hDEAD_BEEF;
        fork
            monitor_loop();
        join_none
        test_reset();
        test_fetch_read();
        test_priority();
        test_starvation("starve", 32'h400);
        test_store();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
